// File: rtl/asip_host_slave_if.sv
// ---------------------------------------------------------------------------
// asip_host_slave_if
//   Tcore host-bus bundle between the external host (master) and the
//   asip_host_slave responder (slave).
//
//   Signals:
//     t_cs     host chip select. An access starts on its rising edge as seen
//              by the slave clock.
//     t_rw     1 = read, 0 = write. Sampled together with t_cs.
//     t_addr   byte address, word aligned. Bits [1:0] are ignored.
//     t_wdata  write data. Sampled together with t_cs.
//     t_rdata  registered read data from the slave.
//
//   Protocol: this bus has no valid/ready pair. t_cs acts as "valid" and the
//   slave is always ready. The slave samples t_rw/t_addr/t_wdata on the first
//   clock edge where t_cs is seen high. t_rdata is stable from the second
//   edge after that one until the next read updates it. The host must drop
//   t_cs for at least one cycle between accesses. Keeping t_cs high never
//   starts a second access.
// ---------------------------------------------------------------------------
interface asip_host_slave_if #(
    parameter int ADDRW = 18,
    parameter int DATW  = 32
);
    logic             t_cs;
    logic             t_rw;
    logic [ADDRW-1:0] t_addr;
    logic [DATW-1:0]  t_wdata;
    logic [DATW-1:0]  t_rdata;

    modport master (
        output t_cs,
        output t_rw,
        output t_addr,
        output t_wdata,
        input  t_rdata
    );

    modport slave (
        input  t_cs,
        input  t_rw,
        input  t_addr,
        input  t_wdata,
        output t_rdata
    );
endinterface

// File: rtl/asip_host_slave.sv
// ---------------------------------------------------------------------------
// asip_host_slave
//   Host-bus responder for the ASIP. It decodes Tcore host accesses into a
//   small register file, sends a start pulse to the core, tracks the core's
//   busy/done status, counts busy cycles and drives the interrupt line.
//
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous, active-high reset
//     host         Tcore host bus, slave side (t_cs/t_rw/t_addr/t_wdata/t_rdata)
//     int_flag     interrupt = done & int_en
//     core_start   one-cycle start pulse to the core
//     core_busy    core is executing
//     core_done    one-cycle completion pulse from the core
//     dbg_state_o  current access FSM state (0 IDLE, 1 CAPT, 2 RESP, 3 HOLD)
//
//   Register map. The word index is addr[7:2]. Any other set address bit
//   (above bit 7) makes the access unmapped.
//     0x00 CTRL  RW    [0] int_en, [1] auto_clr
//     0x04 GO    W     write -> core_start pulse. Reads as 0.
//     0x08 STAT  R/W1C [0] core_busy (live), [1] done, [2] err
//     0x10 ARG0  RW
//     0x14 ARG1  RW
//     0x18 CYC   R     busy-cycle counter. Saturates at all-ones.
//     0x1C VER   R     VERSION
// ---------------------------------------------------------------------------
module asip_host_slave #(
    parameter int              ADDRW   = 18,
    parameter int              DATW    = 32,
    parameter logic [DATW-1:0] VERSION = 32'h0001_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    asip_host_slave_if.slave       host,
    output logic                   int_flag,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   core_done,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [5:0] IDX_CTRL = 6'h00;
    localparam logic [5:0] IDX_GO   = 6'h01;
    localparam logic [5:0] IDX_STAT = 6'h02;
    localparam logic [5:0] IDX_ARG0 = 6'h04;
    localparam logic [5:0] IDX_ARG1 = 6'h05;
    localparam logic [5:0] IDX_CYC  = 6'h06;
    localparam logic [5:0] IDX_VER  = 6'h07;

    state_t            state_q;
    logic              rw_q;
    logic [ADDRW-1:2]  addr_q;
    logic [DATW-1:0]   wdata_q;
    logic [DATW-1:0]   rdata_q;

    logic              int_en_q;
    logic              auto_clr_q;
    logic [DATW-1:0]   arg0_q;
    logic [DATW-1:0]   arg1_q;
    logic [DATW-1:0]   cyc_q;
    logic [DATW-1:0]   cyc_d;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic              err_d;
    logic              start_q;

    logic [5:0]        word_idx;
    logic              mapped;
    logic [DATW-1:0]   rd_val;
    logic              in_capt;
    logic              wr_acc;
    logic              go_wr;
    logic              go_ok;
    logic              stat_wr;
    logic              err_set;

    // Byte-lane bits of the address do not take part in decoding.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^host.t_addr[1:0];

    assign word_idx = addr_q[7:2];
    assign in_capt  = (state_q == CAPT);
    assign wr_acc   = in_capt & ~rw_q;

    // Decode the latched address and select the read value.
    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        case (word_idx)
            IDX_CTRL: rd_val = {{(DATW-2){1'b0}}, auto_clr_q, int_en_q};
            IDX_GO:   rd_val = '0;
            IDX_STAT: rd_val = {{(DATW-3){1'b0}}, err_q, done_q, core_busy};
            IDX_ARG0: rd_val = arg0_q;
            IDX_ARG1: rd_val = arg1_q;
            IDX_CYC:  rd_val = cyc_q;
            IDX_VER:  rd_val = VERSION;
            default:  mapped = 1'b0;
        endcase
        if (addr_q[ADDRW-1:8] != '0) begin
            mapped = 1'b0;
            rd_val = '0;
        end
    end

    assign go_wr   = wr_acc & mapped & (word_idx == IDX_GO);
    // A GO while the core runs, or while a pulse is still out, is refused.
    assign go_ok   = go_wr & ~core_busy & ~start_q;
    assign stat_wr = wr_acc & mapped & (word_idx == IDX_STAT);
    assign err_set = (in_capt & ~mapped) | (go_wr & ~go_ok);

    // Sticky status. The order matters: a done set from the core beats a
    // clear from either auto_clr or a W1C in the same cycle.
    always_comb begin
        done_d = done_q;
        if (go_ok && auto_clr_q) begin
            done_d = 1'b0;
        end
        if (stat_wr && wdata_q[1]) begin
            done_d = 1'b0;
        end
        if (core_done) begin
            done_d = 1'b1;
        end

        err_d = err_q;
        if (stat_wr && wdata_q[2]) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Busy-cycle counter. It restarts on the edge that raises core_start.
    always_comb begin
        cyc_d = cyc_q;
        if (go_ok) begin
            cyc_d = '0;
        end else if (core_busy && (cyc_q != {DATW{1'b1}})) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            int_en_q   <= 1'b0;
            auto_clr_q <= 1'b0;
            arg0_q     <= '0;
            arg1_q     <= '0;
            cyc_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            start_q <= go_ok;

            case (state_q)
                IDLE: begin
                    if (host.t_cs) begin
                        rw_q    <= host.t_rw;
                        addr_q  <= host.t_addr[ADDRW-1:2];
                        wdata_q <= host.t_wdata;
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    if (rw_q) begin
                        rdata_q <= rd_val;
                    end else if (mapped) begin
                        case (word_idx)
                            IDX_CTRL: begin
                                int_en_q   <= wdata_q[0];
                                auto_clr_q <= wdata_q[1];
                            end
                            IDX_ARG0: arg0_q <= wdata_q;
                            IDX_ARG1: arg1_q <= wdata_q;
                            default: ;
                        endcase
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Wait for t_cs to drop so a long chip select counts as one access.
                    if (!host.t_cs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host.t_rdata = rdata_q;
    assign core_start   = start_q;
    assign int_flag     = done_q & int_en_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_asip_host_slave.sv
module tb_asip_host_slave;

    localparam int ADDRW = 18;
    localparam int DATW  = 32;

    logic       clk;
    logic       reset;
    logic       core_busy;
    logic       core_done;
    logic       int_flag;
    logic       core_start;
    logic [1:0] dbg_state;

    int n_checks;
    int n_fail;
    int start_cnt;

    asip_host_slave_if #(.ADDRW(ADDRW), .DATW(DATW)) bus ();

    asip_host_slave #(
        .ADDRW   (ADDRW),
        .DATW    (DATW),
        .VERSION (32'h0001_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (bus.slave),
        .int_flag    (int_flag),
        .core_start  (core_start),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses at the falling edge. A two-cycle pulse counts twice.
    always @(negedge clk) begin
        if (core_start) start_cnt++;
    end

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One access. t_cs stays high for `hold` edges. If pulse_done is set,
    // core_done is raised on the CAPT edge of the access.
    task automatic host_access(input logic rw, input logic [ADDRW-1:0] addr,
                               input logic [DATW-1:0] wdata, input int hold,
                               input logic pulse_done, output logic [DATW-1:0] rdata);
        @(negedge clk);
        bus.t_cs    = 1'b1;
        bus.t_rw    = rw;
        bus.t_addr  = addr;
        bus.t_wdata = wdata;
        repeat (hold) @(negedge clk);
        bus.t_cs  = 1'b0;
        core_done = pulse_done;
        @(negedge clk);
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        rdata = bus.t_rdata;
    endtask

    task automatic host_write(input logic [ADDRW-1:0] addr, input logic [DATW-1:0] data);
        logic [DATW-1:0] dummy;
        host_access(1'b0, addr, data, 1, 1'b0, dummy);
    endtask

    task automatic host_read(input logic [ADDRW-1:0] addr, output logic [DATW-1:0] data);
        host_access(1'b1, addr, '0, 1, 1'b0, data);
    endtask

    task automatic pulse_core_done();
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [DATW-1:0] rd;
        logic [DATW-1:0] dummy;
        n_checks    = 0;
        n_fail      = 0;
        start_cnt   = 0;
        reset       = 1'b1;
        core_busy   = 1'b0;
        core_done   = 1'b0;
        bus.t_cs    = 1'b0;
        bus.t_rw    = 1'b0;
        bus.t_addr  = '0;
        bus.t_wdata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_rdata", bus.t_rdata, 32'h0);
        check_val("rst_int", {31'b0, int_flag}, 32'h0);
        check_val("rst_start", {31'b0, core_start}, 32'h0);
        check_val("rst_state", {30'b0, dbg_state}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        host_read(18'h00, rd);  check_val("rst_ctrl", rd, 32'h0);
        host_read(18'h08, rd);  check_val("rst_stat", rd, 32'h0);
        host_read(18'h18, rd);  check_val("rst_cyc", rd, 32'h0);
        host_read(18'h1C, rd);  check_val("ver", rd, 32'h0001_0000);

        // 1. scratch registers
        host_write(18'h10, 32'hDEAD_BEEF);
        host_read(18'h10, rd);  check_val("arg0", rd, 32'hDEAD_BEEF);
        host_write(18'h14, 32'h1234_5678);
        check_val("rdata_hold", bus.t_rdata, 32'hDEAD_BEEF);
        host_read(18'h14, rd);  check_val("arg1", rd, 32'h1234_5678);
        host_read(18'h04, rd);  check_val("go_reads0", rd, 32'h0);

        // 2. GO, busy for 20 cycles, then done
        host_write(18'h04, 32'h0);
        check_val("go_pulse", start_cnt, 1);
        @(negedge clk);
        core_busy = 1'b1;
        repeat (20) @(negedge clk);
        core_busy = 1'b0;
        pulse_core_done();
        host_read(18'h18, rd);  check_val("cyc20", rd, 32'd20);
        host_read(18'h08, rd);  check_val("stat_done", rd, 32'h2);

        // 3. interrupt path
        host_write(18'h08, 32'h2);
        host_write(18'h00, 32'h1);
        check_val("int_idle", {31'b0, int_flag}, 32'h0);
        host_read(18'h00, rd);  check_val("ctrl", rd, 32'h1);
        pulse_core_done();
        check_val("int_set", {31'b0, int_flag}, 32'h1);
        host_write(18'h08, 32'h2);
        check_val("int_w1c", {31'b0, int_flag}, 32'h0);
        host_access(1'b0, 18'h08, 32'h2, 1, 1'b1, dummy);
        check_val("int_same_cyc", {31'b0, int_flag}, 32'h1);
        host_read(18'h08, rd);  check_val("done_wins", rd, 32'h2);
        host_write(18'h00, 32'h0);
        check_val("int_en_clr", {31'b0, int_flag}, 32'h0);

        // 4. refused GO, unmapped accesses
        @(negedge clk);
        core_busy = 1'b1;
        host_write(18'h04, 32'h0);
        core_busy = 1'b0;
        check_val("go_busy_nopulse", start_cnt, 1);
        host_read(18'h08, rd);  check_val("stat_err_go", rd, 32'h6);
        host_write(18'h08, 32'h4);
        host_read(18'h08, rd);  check_val("err_w1c", rd, 32'h2);
        host_read(18'h3FFFC, rd); check_val("unmapped_rd", rd, 32'h0);
        host_read(18'h08, rd);  check_val("stat_err_unm", rd, 32'h6);
        host_write(18'h110, 32'h0000_FFFF);
        host_read(18'h10, rd);  check_val("unmapped_wr", rd, 32'hDEAD_BEEF);
        host_read(18'h0C, rd);  check_val("hole_rd", rd, 32'h0);

        // auto_clr: GO clears done and CYC
        host_write(18'h08, 32'h6);
        host_read(18'h08, rd);  check_val("stat_clr", rd, 32'h0);
        host_write(18'h00, 32'h2);
        host_read(18'h00, rd);  check_val("ctrl_ac", rd, 32'h2);
        pulse_core_done();
        host_write(18'h04, 32'h0);
        check_val("go_pulse2", start_cnt, 2);
        host_read(18'h08, rd);  check_val("auto_clr", rd, 32'h0);
        host_read(18'h18, rd);  check_val("cyc_clr", rd, 32'h0);

        // 5. long chip select is a single access
        host_access(1'b0, 18'h04, 32'h0, 10, 1'b0, dummy);
        check_val("long_cs", start_cnt, 3);

        // 6. reset during the CAPT cycle of a write
        host_read(18'h14, rd);  check_val("arg1_pre", rd, 32'h1234_5678);
        @(negedge clk);
        bus.t_cs    = 1'b1;
        bus.t_rw    = 1'b0;
        bus.t_addr  = 18'h14;
        bus.t_wdata = 32'h5;
        @(negedge clk);
        check_val("in_capt", {30'b0, dbg_state}, 32'h1);
        reset    = 1'b1;
        #1;
        check_val("rst_mid_state", {30'b0, dbg_state}, 32'h0);
        check_val("rst_mid_rdata", bus.t_rdata, 32'h0);
        bus.t_cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_mid_start", start_cnt, 3);
        host_read(18'h14, rd);  check_val("arg1_lost", rd, 32'h0);
        host_read(18'h00, rd);  check_val("ctrl_rst", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
